// File: rtl/ahb_mtx_pkg.sv
// Shared AHB encodings and burst-tracker state for the bus-matrix output-stage arbiter.
package ahb_mtx_pkg;

    localparam logic [1:0] TRN_IDLE   = 2'b00;
    localparam logic [1:0] TRN_BUSY   = 2'b01;
    localparam logic [1:0] TRN_NONSEQ = 2'b10;
    localparam logic [1:0] TRN_SEQ    = 2'b11;

    localparam logic [2:0] BUR_SINGLE = 3'd0;
    localparam logic [2:0] BUR_INCR   = 3'd1;
    localparam logic [2:0] BUR_WRAP4  = 3'd2;
    localparam logic [2:0] BUR_INCR4  = 3'd3;
    localparam logic [2:0] BUR_WRAP8  = 3'd4;
    localparam logic [2:0] BUR_INCR8  = 3'd5;
    localparam logic [2:0] BUR_WRAP16 = 3'd6;
    localparam logic [2:0] BUR_INCR16 = 3'd7;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam int unsigned REMAIN_W = 4;
    localparam int unsigned EARLY_W  = 2;

    typedef struct packed {
        logic [REMAIN_W-1:0] remain;
        logic                hold;
        logic [EARLY_W-1:0]  early;
    } burst_state_t;

endpackage

// File: rtl/ahb_mtx_burst_tracker.sv
// Tracks remaining beats of the granted burst and tells the arbiter whether to hold the grant.
module ahb_mtx_burst_tracker
    import ahb_mtx_pkg::*;
#(
    parameter int unsigned INCR_HOLD_BEATS  = 4,
    parameter int unsigned EARLY_INCR_LIMIT = 1
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    output logic       next_hold_c
);

    burst_state_t         st_q;
    burst_state_t         st_d;
    logic [EARLY_W-1:0]   early_inc;

    always_comb begin
        st_d      = st_q;
        early_inc = st_q.early;
        // A NONSEQ arriving while still holding means the previous burst was cut short.
        if (st_q.hold && (HTRANSM == TRN_NONSEQ) && (st_q.early < EARLY_W'(EARLY_INCR_LIMIT)))
            early_inc = st_q.early + EARLY_W'(1);

        if (!HSELM || (HTRANSM == TRN_IDLE)) begin
            st_d.remain = '0;
            st_d.hold   = 1'b0;
        end else if (HTRANSM == TRN_SEQ) begin
            if (st_q.remain == '0) st_d.hold = 1'b0;
            else                   st_d.remain = st_q.remain - REMAIN_W'(1);
        end else if (HTRANSM == TRN_NONSEQ) begin
            case (HBURSTM)
                BUR_WRAP16, BUR_INCR16: begin st_d.remain = REMAIN_W'(14); st_d.hold = 1'b1; end
                BUR_WRAP8,  BUR_INCR8:  begin st_d.remain = REMAIN_W'(6);  st_d.hold = 1'b1; end
                BUR_WRAP4,  BUR_INCR4:  begin st_d.remain = REMAIN_W'(2);  st_d.hold = 1'b1; end
                BUR_INCR: begin
                    if (early_inc < EARLY_W'(EARLY_INCR_LIMIT)) begin
                        st_d.remain = REMAIN_W'(INCR_HOLD_BEATS - 2);
                        st_d.hold   = 1'b1;
                    end else begin
                        st_d.remain = '0;
                        st_d.hold   = 1'b0;
                    end
                end
                default: begin st_d.remain = '0; st_d.hold = 1'b0; end
            endcase
        end

        st_d.early = st_d.hold ? early_inc : '0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)       st_q <= '0;
        else if (HREADYM) st_q <= st_d;
    end

    assign next_hold_c = st_d.hold;

endmodule

// File: rtl/ahb_mtx_arbiter_param.sv
// Output-stage arbiter for one AHB matrix slave port: masked round-robin or fixed-priority
// grant selection with lock and burst hold, exposing the grant as index and one-hot.
module ahb_mtx_arbiter_param
    import ahb_mtx_pkg::*;
#(
    parameter int unsigned          NUM_PORTS        = 4,
    parameter logic [NUM_PORTS-1:0] PORT_MASK        = 4'b1101,
    parameter int unsigned          ARB_MODE         = 0,
    parameter int unsigned          INCR_HOLD_BEATS  = 4,
    parameter int unsigned          EARLY_INCR_LIMIT = 1,
    localparam int unsigned         PORT_W           = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic [NUM_PORTS-1:0] grant_onehot
);

    logic                 next_hold_c;
    logic [NUM_PORTS-1:0] req_m;
    logic [PORT_W-1:0]    addr_q, addr_d, low_idx, rr_idx;
    logic                 no_q, no_d, low_hit, rr_hit;
    logic [NUM_PORTS-1:0] oh_q, oh_d;
    int unsigned          rr_pos;

    ahb_mtx_burst_tracker #(
        .INCR_HOLD_BEATS  (INCR_HOLD_BEATS),
        .EARLY_INCR_LIMIT (EARLY_INCR_LIMIT)
    ) u_burst (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HREADYM     (HREADYM),
        .HSELM       (HSELM),
        .HTRANSM     (HTRANSM),
        .HBURSTM     (HBURSTM),
        .next_hold_c (next_hold_c)
    );

    assign req_m = req_port & PORT_MASK;

    always_comb begin
        addr_d  = addr_q;
        no_d    = no_q;
        low_idx = '0;
        low_hit = 1'b0;
        rr_idx  = '0;
        rr_hit  = 1'b0;
        rr_pos  = 0;

        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (req_m[PORT_W'(i)] && !low_hit) begin
                low_hit = 1'b1;
                low_idx = PORT_W'(i);
            end
        end

        // Rotating search starts after the current owner; the owner itself is visited last.
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            rr_pos = 32'(addr_q) + k;
            if (rr_pos >= NUM_PORTS) rr_pos = rr_pos - NUM_PORTS;
            if (req_m[PORT_W'(rr_pos)] && !rr_hit) begin
                rr_hit = 1'b1;
                rr_idx = PORT_W'(rr_pos);
            end
        end

        if (HMASTLOCKM || next_hold_c) begin
            addr_d = addr_q;
        end else if (no_q) begin
            if (low_hit) begin
                addr_d = low_idx;
                no_d   = 1'b0;
            end
        end else if (ARB_MODE == ARB_FIXED) begin
            if (low_hit) begin
                addr_d = low_idx;
                no_d   = 1'b0;
            end else if (!HSELM) begin
                no_d = 1'b1;
            end
        end else begin
            if (rr_hit) begin
                addr_d = rr_idx;
                no_d   = 1'b0;
            end else if (!HSELM) begin
                no_d = 1'b1;
            end
        end

        oh_d = no_d ? '0 : (NUM_PORTS'(1) << addr_d);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q <= '0;
            no_q   <= 1'b1;
            oh_q   <= '0;
        end else if (HREADYM) begin
            addr_q <= addr_d;
            no_q   <= no_d;
            oh_q   <= oh_d;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_q;
    assign grant_onehot = oh_q;

endmodule

// File: tb/tb_ahb_mtx_arbiter_param.sv
// Directed bench for the output-stage arbiter: a round-robin instance (mask 1101) and a
// fixed-priority instance (all ports connected) share stimulus; expectations are queued and checked.
module tb_ahb_mtx_arbiter_param;
    import ahb_mtx_pkg::*;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] req_port;
    logic       HREADYM, HSELM, HMASTLOCKM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;

    logic [1:0] rr_addr, fx_addr;
    logic       rr_no, fx_no;
    logic [3:0] rr_oh, fx_oh;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         fix;
        logic       no;
        logic [1:0] addr;
        logic [3:0] oh;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 HCLK = ~HCLK;

    ahb_mtx_arbiter_param #(.NUM_PORTS(4), .PORT_MASK(4'b1101), .ARB_MODE(ARB_RR)) u_rr (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
        .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(rr_addr), .no_port(rr_no), .grant_onehot(rr_oh)
    );

    ahb_mtx_arbiter_param #(.NUM_PORTS(4), .PORT_MASK(4'b1111), .ARB_MODE(ARB_FIXED)) u_fix (
        .HCLK(HCLK), .HRESET(HRESET), .req_port(req_port), .HREADYM(HREADYM), .HSELM(HSELM),
        .HTRANSM(HTRANSM), .HBURSTM(HBURSTM), .HMASTLOCKM(HMASTLOCKM),
        .addr_in_port(fx_addr), .no_port(fx_no), .grant_onehot(fx_oh)
    );

    // Drive one cycle of inputs, queue the expected grant, then check it after the edge.
    task automatic step(input logic [3:0] req, input logic sel, input logic [1:0] trn,
                        input logic [2:0] bur, input logic lock, input logic rdy,
                        input logic rst, input bit fix, input logic eno,
                        input logic [1:0] eaddr, input string tag);
        exp_t       e;
        logic [3:0] one;
        logic       o_no;
        logic [1:0] o_addr;
        logic [3:0] o_oh;
        req_port   = req;
        HSELM      = sel;
        HTRANSM    = trn;
        HBURSTM    = bur;
        HMASTLOCKM = lock;
        HREADYM    = rdy;
        HRESET     = rst;
        one        = 4'b0001;
        e.fix  = fix;
        e.no   = eno;
        e.addr = eaddr;
        e.oh   = eno ? 4'b0000 : (one << eaddr);
        e.tag  = tag;
        exp_q.push_back(e);
        @(posedge HCLK);
        #1;
        e = exp_q.pop_front();
        o_no   = e.fix ? fx_no   : rr_no;
        o_addr = e.fix ? fx_addr : rr_addr;
        o_oh   = e.fix ? fx_oh   : rr_oh;
        checks++;
        assert (o_no === e.no) else begin
            errors++;
            $error("FAIL %s no_port observed %0b expected %0b", e.tag, o_no, e.no);
        end
        checks++;
        assert (o_addr === e.addr) else begin
            errors++;
            $error("FAIL %s addr_in_port observed %0d expected %0d", e.tag, o_addr, e.addr);
        end
        checks++;
        assert (o_oh === e.oh) else begin
            errors++;
            $error("FAIL %s grant_onehot observed %b expected %b", e.tag, o_oh, e.oh);
        end
    endtask

    initial begin
        HRESET = 1'b1; req_port = '0; HREADYM = 1'b1; HSELM = 1'b0;
        HTRANSM = TRN_IDLE; HBURSTM = BUR_SINGLE; HMASTLOCKM = 1'b0;

        // Reset wins over requests and HREADYM
        step(4'b1101, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 1, 0, 1, 0, "rst_rdy1");
        step(4'b1101, 1, TRN_NONSEQ, BUR_SINGLE, 0, 0, 1, 0, 1, 0, "rst_rdy0");
        step(4'b1111, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 1, 1, 1, 0, "rst_fix");

        // Round-robin over masked requesters; port 1 never granted
        step(4'b1101, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 0, 0, 0, 0, "rr_0");
        step(4'b1101, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 0, 0, 0, 2, "rr_2");
        step(4'b1101, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 0, 0, 0, 3, "rr_3");
        step(4'b1101, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 0, 0, 0, 0, "rr_wrap0");
        step(4'b1101, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 0, 0, 0, 2, "rr_2b");
        step(4'b1101, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 0, 0, 0, 3, "rr_3b");

        // INCR8 from port 0 with a BUSY; port 2 waits for the eighth beat
        step(4'b0101, 1, TRN_IDLE,   BUR_SINGLE, 0, 1, 0, 0, 0, 0, "i8_grant0");
        step(4'b0101, 1, TRN_NONSEQ, BUR_INCR8,  0, 1, 0, 0, 0, 0, "i8_b1");
        step(4'b0101, 1, TRN_SEQ,    BUR_INCR8,  0, 1, 0, 0, 0, 0, "i8_b2");
        step(4'b0101, 1, TRN_SEQ,    BUR_INCR8,  0, 1, 0, 0, 0, 0, "i8_b3");
        step(4'b0101, 1, TRN_BUSY,   BUR_INCR8,  0, 1, 0, 0, 0, 0, "i8_busy");
        step(4'b0101, 1, TRN_SEQ,    BUR_INCR8,  0, 1, 0, 0, 0, 0, "i8_b4");
        step(4'b0101, 1, TRN_SEQ,    BUR_INCR8,  0, 1, 0, 0, 0, 0, "i8_b5");
        step(4'b0101, 1, TRN_SEQ,    BUR_INCR8,  0, 1, 0, 0, 0, 0, "i8_b6");
        step(4'b0101, 1, TRN_SEQ,    BUR_INCR8,  0, 1, 0, 0, 0, 0, "i8_b7");
        step(4'b0101, 1, TRN_SEQ,    BUR_INCR8,  0, 1, 0, 0, 0, 2, "i8_b8_to2");

        // Back-to-back short INCR from port 3: the second NONSEQ does not hold
        step(4'b1001, 1, TRN_IDLE,   BUR_SINGLE, 0, 1, 0, 0, 0, 3, "incr_grant3");
        step(4'b1001, 1, TRN_NONSEQ, BUR_INCR,   0, 1, 0, 0, 0, 3, "incr1_ns");
        step(4'b1001, 1, TRN_SEQ,    BUR_INCR,   0, 1, 0, 0, 0, 3, "incr1_seq");
        step(4'b1001, 1, TRN_NONSEQ, BUR_INCR,   0, 1, 0, 0, 0, 0, "incr2_to0");

        // HREADYM low freezes everything while requests move
        step(4'b0001, 0, TRN_IDLE,   BUR_SINGLE, 0, 0, 0, 0, 0, 0, "frz_1");
        step(4'b0001, 0, TRN_IDLE,   BUR_SINGLE, 0, 0, 0, 0, 0, 0, "frz_2");
        step(4'b1000, 0, TRN_IDLE,   BUR_SINGLE, 0, 0, 0, 0, 0, 0, "frz_3");
        step(4'b1000, 0, TRN_IDLE,   BUR_SINGLE, 0, 0, 0, 0, 0, 0, "frz_4");
        step(4'b1000, 0, TRN_IDLE,   BUR_SINGLE, 0, 0, 0, 0, 0, 0, "frz_5");
        step(4'b1000, 0, TRN_IDLE,   BUR_SINGLE, 0, 1, 0, 0, 0, 3, "unfrz_3");

        // Reset in the middle of INCR16 leaves no residual hold
        step(4'b1000, 1, TRN_NONSEQ, BUR_INCR16, 0, 1, 0, 0, 0, 3, "i16_ns");
        step(4'b1000, 1, TRN_SEQ,    BUR_INCR16, 0, 1, 0, 0, 0, 3, "i16_seq");
        step(4'b1000, 1, TRN_SEQ,    BUR_INCR16, 0, 1, 1, 0, 1, 0, "i16_rst");
        step(4'b0001, 1, TRN_SEQ,    BUR_INCR16, 0, 1, 0, 0, 0, 0, "i16_after");

        // Fixed priority: lowest index beats current owner; lock holds the grant
        step(4'b0000, 0, TRN_IDLE,   BUR_SINGLE, 0, 1, 1, 1, 1, 0, "fx_rst");
        step(4'b1000, 1, TRN_IDLE,   BUR_SINGLE, 0, 1, 0, 1, 0, 3, "fx_3");
        step(4'b0110, 1, TRN_BUSY,   BUR_SINGLE, 0, 1, 0, 1, 0, 1, "fx_1");
        step(4'b0111, 1, TRN_NONSEQ, BUR_SINGLE, 1, 1, 0, 1, 0, 1, "fx_lock_a");
        step(4'b0111, 1, TRN_NONSEQ, BUR_SINGLE, 1, 1, 0, 1, 0, 1, "fx_lock_b");
        step(4'b0111, 1, TRN_NONSEQ, BUR_SINGLE, 0, 1, 0, 1, 0, 0, "fx_unlock_0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
